neuron_weighted_sum: RTL and testbench

//  Upstream stage of Elliot_Activation: computes one neuron's pre-activation

---
 rtl/neuron_weighted_sum.sv | 164 ++++++++++++++++
 tb/tb_neuron_weighted_sum.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_weighted_sum.sv
// ---------------------------------------------------------------------------
// neuron_weighted_sum
//   Computes one neuron's pre-activation value
//     sum = bias + SUM(x_i * w_i)
//   over N_INPUTS streamed (x, w) pairs. All external data is signed Q16.16.
//   Each product is formed at full 64-bit precision, shifted back to Q16.16
//   (arithmetic shift, i.e. floor), and accumulated at ACC_W bits. The bias
//   is added after the last pair, and the result is converted to 32 bits.
//
//   Build option:
//     NEURON_SAT_EN  defined   -> result saturates to the 32-bit signed range
//                    undefined -> result is acc[31:0] (two's-complement wrap)
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous reset, active-high
//   start       in   1   one-cycle pulse: begin evaluation, latch bias
//   bias        in   32  signed Q16.16 bias, sampled when start is accepted
//   in_valid    in   1   x_in/w_in hold a valid pair
//   in_ready    out  1   block accepts a pair this cycle
//   x_in        in   32  signed Q16.16 input activation
//   w_in        in   32  signed Q16.16 weight
//   sum         out  32  signed Q16.16 result, held until next completion
//   end_signal  out  1   one-cycle pulse: sum is valid
//   busy        out  1   high from accepted start through the end_signal cycle
// ---------------------------------------------------------------------------
module neuron_weighted_sum #(
  parameter int N_INPUTS = 3,
  parameter int ACC_W    = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] w_in,
  output logic [31:0] sum,
  output logic        end_signal,
  output logic        busy
);

  // Counter must hold values 0..N_INPUTS-1; one extra value keeps N_INPUTS=1 legal.
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  // 32-bit signed range limits expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-31){1'b0}}, 31'h7FFF_FFFF};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-31){1'b1}}, 31'h0000_0000};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_reg, state_next;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]         count_reg, count_next;
  logic [31:0]              bias_reg, bias_next;
  logic [31:0]              sum_reg, sum_next;
  logic                     end_reg, end_next;

  logic signed [63:0]       prod;
  logic signed [63:0]       prod_shift;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  bias_ext;

  // Full-precision Q32.32 product, then back to Q16.16 with floor rounding.
  assign prod       = $signed({{32{x_in[31]}}, x_in}) * $signed({{32{w_in[31]}}, w_in});
  assign prod_shift = prod >>> 16;
  assign term       = ACC_W'(prod_shift);
  assign bias_ext   = {{(ACC_W-32){bias_reg[31]}}, bias_reg};

  function automatic logic [31:0] convert(input logic signed [ACC_W-1:0] a);
`ifdef NEURON_SAT_EN
    if (a > SAT_MAX) begin
      return 32'h7FFF_FFFF;
    end else if (a < SAT_MIN) begin
      return 32'h8000_0000;
    end else begin
      return 32'(a);
    end
`else
    return 32'(a);
`endif
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      bias_reg  <= '0;
      sum_reg   <= '0;
      end_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      bias_reg  <= bias_next;
      sum_reg   <= sum_next;
      end_reg   <= end_next;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    bias_next  = bias_reg;
    sum_next   = sum_reg;
    end_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next   = '0;
          count_next = '0;
          bias_next  = bias;
          state_next = ACCUM;
        end
      end

      ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone decides acceptance.
        if (in_valid) begin
          acc_next   = acc_reg + term;
          count_next = CNT_W'(count_reg + 1'b1);
          if (count_reg == LAST_IDX) begin
            state_next = BIAS;
          end
        end
      end

      BIAS: begin
        // The result register and end pulse are loaded on the same edge that
        // enters DONE, so sum is already valid while end_signal is high.
        acc_next   = acc_reg + bias_ext;
        sum_next   = convert(acc_next);
        end_next   = 1'b1;
        state_next = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready   = (state_reg == ACCUM);
  assign busy       = (state_reg != IDLE);
  assign end_signal = end_reg;
  assign sum        = sum_reg;

endmodule

// File: tb/tb_neuron_weighted_sum.sv
// ---------------------------------------------------------------------------
// tb_neuron_weighted_sum
//   Two instances: dut_a with N_INPUTS=3 and dut_b with N_INPUTS=1.
//   Expected sums are pushed to a queue when a start is issued and popped
//   when end_signal appears.
// ---------------------------------------------------------------------------
module tb_neuron_weighted_sum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a: N_INPUTS = 3
  logic        start_a, in_valid_a, in_ready_a, end_a, busy_a;
  logic [31:0] bias_a, x_a, w_a, sum_a;
  // dut_b: N_INPUTS = 1
  logic        start_b, in_valid_b, in_ready_b, end_b, busy_b;
  logic [31:0] bias_b, x_b, w_b, sum_b;

  neuron_weighted_sum #(.N_INPUTS(3), .ACC_W(48)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bias(bias_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .x_in(x_a), .w_in(w_a),
    .sum(sum_a), .end_signal(end_a), .busy(busy_a)
  );

  neuron_weighted_sum #(.N_INPUTS(1), .ACC_W(48)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bias(bias_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .x_in(x_b), .w_in(w_b),
    .sum(sum_b), .end_signal(end_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // Count end_signal high cycles per instance.
  int ends_a = 0;
  int ends_b = 0;
  always @(negedge clk) begin
    if (end_a === 1'b1) ends_a++;
    if (end_b === 1'b1) ends_b++;
  end

  // Stimulus vectors
  logic [31:0] t1_x[3] = '{32'h0001_0000, 32'h0002_0000, 32'hFFFF_8000};
  logic [31:0] t1_w[3] = '{32'h0000_8000, 32'h0000_4000, 32'h0002_0000};
  logic [31:0] t3_x[3] = '{32'h7FFF_0000, 32'h0, 32'h0};
  logic [31:0] t3_w[3] = '{32'h7FFF_0000, 32'h0, 32'h0};
  logic [31:0] t6_x[3] = '{32'hFFFE_0000, 32'h0, 32'h0};
  logic [31:0] t6_w[3] = '{32'h0003_0000, 32'h0, 32'h0};

`ifdef NEURON_SAT_EN
  localparam logic [31:0] T3_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] T3_EXP = 32'h0001_0000;
`endif

  task automatic set_in(input int which, input logic st, input logic [31:0] b,
                        input logic v, input logic [31:0] x, input logic [31:0] w);
    if (which == 0) begin
      start_a = st; bias_a = b; in_valid_a = v; x_a = x; w_a = w;
    end else begin
      start_b = st; bias_b = b; in_valid_b = v; x_b = x; w_b = w;
    end
  endtask

  function automatic logic get_ready(input int which);
    return (which == 0) ? in_ready_a : in_ready_b;
  endfunction
  function automatic logic get_end(input int which);
    return (which == 0) ? end_a : end_b;
  endfunction
  function automatic logic get_busy(input int which);
    return (which == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic [31:0] get_sum(input int which);
    return (which == 0) ? sum_a : sum_b;
  endfunction
  function automatic int get_ends(input int which);
    return (which == 0) ? ends_a : ends_b;
  endfunction

  // One evaluation. gap: idle cycles before each pair; restart_at: pair index
  // during which a spurious start is pulsed (-1 none); abort_after: assert rst
  // after this many accepts (0 none); start_in_done: pulse start in DONE.
  task automatic run_eval(input int which, input string name, input logic [31:0] b,
                          input logic [31:0] xs[3], input logic [31:0] ws[3],
                          input int n, input logic [31:0] expv, input int gap,
                          input int restart_at, input int abort_after,
                          input bit start_in_done);
    int ends0;
    int budget;
    int cyc;
    logic [31:0] got;
    exp_q.push_back(expv);
    ends0 = get_ends(which);
    @(posedge clk); #1;
    set_in(which, 1'b1, b, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    set_in(which, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (get_busy(which) !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_start: got %b want 1", name, get_busy(which));
    end
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        n_checks++;
        if (get_ready(which) !== 1'b1) begin
          n_fail++; $display("FAIL %s ready_in_gap: got %b want 1", name, get_ready(which));
        end
      end
      set_in(which, (i == restart_at), 32'hDEAD_BEEF, 1'b1, xs[i], ws[i]);
      budget = 0;
      while (get_ready(which) !== 1'b1 && budget < 20) begin
        @(posedge clk); #1;
        budget++;
      end
      if (budget >= 20) begin
        n_checks++; n_fail++;
        $display("FAIL %s ready_timeout: got 0 want 1", name);
      end
      @(posedge clk); #1;
      set_in(which, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      if (abort_after == i + 1) begin
        rst = 1'b1;
        #1;
        n_checks++;
        if (get_sum(which) !== 32'h0 || get_end(which) !== 1'b0 ||
            get_ready(which) !== 1'b0 || get_busy(which) !== 1'b0) begin
          n_fail++;
          $display("FAIL %s async_reset: sum=%h end=%b ready=%b busy=%b want 0/0/0/0",
                   name, get_sum(which), get_end(which), get_ready(which), get_busy(which));
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        $display("%s: evaluation aborted by reset", name);
        return;
      end
    end
    // The last accepting edge has passed; end_signal must rise on the next edge.
    cyc = 0;
    while (get_end(which) !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc != 1) begin
      n_fail++; $display("FAIL %s end_latency: got %0d edges want 1", name, cyc);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s scoreboard_empty: got 0 entries want 1", name);
    end else begin
      got = exp_q.pop_front();
      if (get_sum(which) !== got) begin
        n_fail++; $display("FAIL %s sum: got %h want %h", name, get_sum(which), got);
      end
    end
    n_checks++;
    if (get_busy(which) !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_in_end_cycle: got %b want 1", name, get_busy(which));
    end
    if (start_in_done) set_in(which, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    set_in(which, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (get_end(which) !== 1'b0 || get_busy(which) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_end: end=%b busy=%b want 0/0", name, get_end(which), get_busy(which));
    end
    n_checks++;
    if (get_sum(which) !== expv) begin
      n_fail++; $display("FAIL %s sum_held: got %h want %h", name, get_sum(which), expv);
    end
    @(posedge clk); #1;
    n_checks++;
    if (get_ends(which) - ends0 !== 1) begin
      n_fail++; $display("FAIL %s end_pulse_count: got %0d want 1", name, get_ends(which) - ends0);
    end
    $display("%s: sum=%h expected=%h latency=%0d", name, get_sum(which), expv, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    set_in(1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sum_a !== 32'h0 || end_a !== 1'b0 || in_ready_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: sum=%h end=%b ready=%b busy=%b want 0/0/0/0", sum_a, end_a, in_ready_a, busy_a);
    end
    n_checks++;
    if (sum_b !== 32'h0 || end_b !== 1'b0 || in_ready_b !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: sum=%h end=%b ready=%b busy=%b want 0/0/0/0", sum_b, end_b, in_ready_b, busy_b);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: outputs cleared");
  endtask

  task automatic test_streaming();
    run_eval(0, "T1_stream", 32'h0001_8000, t1_x, t1_w, 3, 32'h0001_8000, 0, -1, 0, 1'b0);
  endtask

  task automatic test_gaps();
    run_eval(0, "T2_gaps", 32'h0001_8000, t1_x, t1_w, 3, 32'h0001_8000, 2, -1, 0, 1'b0);
  endtask

  task automatic test_overflow();
    run_eval(1, "T3_overflow", 32'h0, t3_x, t3_w, 1, T3_EXP, 0, -1, 0, 1'b0);
  endtask

  task automatic test_restart_ignored();
    run_eval(0, "T4_restart", 32'h0001_8000, t1_x, t1_w, 3, 32'h0001_8000, 0, 1, 0, 1'b0);
  endtask

  task automatic test_reset_midway();
    run_eval(0, "T5_abort", 32'h0001_8000, t1_x, t1_w, 3, 32'h0001_8000, 0, -1, 2, 1'b0);
    run_eval(0, "T5_fresh", 32'h0001_8000, t1_x, t1_w, 3, 32'h0001_8000, 0, -1, 0, 1'b0);
  endtask

  task automatic test_negative();
    run_eval(1, "T6_negative", 32'hFFFF_0000, t6_x, t6_w, 1, 32'hFFF9_0000, 0, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_eval(0, "B2B_first", 32'h0001_8000, t1_x, t1_w, 3, 32'h0001_8000, 0, -1, 0, 1'b1);
    run_eval(0, "B2B_second", 32'h0000_0000, t1_x, t1_w, 3, 32'h0000_0000, 0, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_gaps();
    test_overflow();
    test_restart_ignored();
    test_reset_midway();
    test_negative();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
